// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } timer_state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Any nibble above 9 is not a legal BCD digit; treat it as 9.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] x);
      return (x > BCD_MAX) ? BCD_MAX : x;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade of the countdown chain. Decrements when dec_in is high;
// a digit at 0 wraps to 9 and passes a borrow to the next decade.
module bcd_down_digit
   import timer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec_in,
   output logic [3:0] q,
   output logic       borrow_out
);

   // A borrow leaves this decade only when it is asked to decrement while at 0.
   assign borrow_out = dec_in & (q == 4'd0);

   // Digit register: reset, then load, then decrement.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         q <= 4'd0;
      end else if (load) begin
         q <= load_val;
      end else if (dec_in) begin
         q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: loads a preset, decrements once per
// prescaled tick with borrows rippling across decades, and pulses done at 0.
module bcd_down_timer
   import timer_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set,
   input  logic [4*DIGITS-1:0]   setValue,
   input  logic                  start,
   input  logic                  pause,
   output logic [4*DIGITS-1:0]   q,
   output logic                  running,
   output logic                  zero,
   output logic                  done
);

   localparam int                PW         = $clog2(TICK_DIV + 1);
   localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [4*DIGITS-1:0] Q_ONE    = (4*DIGITS)'(1);

   timer_state_t      state_q, state_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic              tick;
   logic              reach_zero;
   logic [DIGITS:0]   dec_chain;
   logic              top_borrow_unused;

   assign zero       = (q == '0);
   assign reach_zero = tick & (q == Q_ONE);

   // Next-state, prescaler and tick decode; set overrides every state.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      state_d = state_q;
      presc_d = presc_q;
      tick    = 1'b0;
      if (set) begin
         state_d = IDLE;
         presc_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !zero) begin
                  state_d = RUN;
                  presc_d = '0;
               end
            end
            RUN: begin
               if (pause) begin
                  state_d = PAUSE;
               end else if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  tick    = 1'b1;
                  if (q == Q_ONE) state_d = DONE;
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            PAUSE: begin
               if (start) state_d = RUN;
            end
            DONE: begin
               state_d = DONE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, prescaler and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         presc_q <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         running <= (state_d == RUN);
         done    <= reach_zero && !set;
      end
   end

   // Borrow chain: the tick enters digit 0, each borrow feeds the next decade.
   assign dec_chain[0] = tick;

   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         bcd_down_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (set),
            .load_val   (bcd_clamp(setValue[4*k +: 4])),
            .dec_in     (dec_chain[k]),
            .q          (q[4*k +: 4]),
            .borrow_out (dec_chain[k+1])
         );
      end
   endgenerate

   // A borrow out of the top decade would mean underflow, which RUN never allows.
   assign top_borrow_unused = dec_chain[DIGITS];

endmodule
